pb_debounce_multi: RTL and testbench

Parametrised, multi-channel push-button debouncer: the next generation of the board-level button conditioning used in front of the multi-cycle CPU's step/run/reset controls. It synchronises N_CH raw, asynchronous inputs, samples them on a shared clock-enable tick, and produces a debounced level per channel. It also produces one-cycle press, release and long-press pulses. Everything runs in the single `clk` domain; no derived clocks.

---
 rtl/pb_debounce_multi.sv | 110 +++++++++++
 tb/tb_pb_debounce_multi.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/pb_debounce_multi.sv
// Multi-channel push-button conditioner: per-channel 2-flop synchroniser, shared sample tick,
// SAMPLES-deep qualification window, and one-cycle press / release / long-press pulses.
module pb_debounce_multi #(
  parameter int N_CH       = 4,
  parameter int CLK_DIV    = 50000,
  parameter int SAMPLES    = 8,
  parameter int HOLD_TICKS = 1000
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic [N_CH-1:0] button_i,
  output logic [N_CH-1:0] button_out_o,
  output logic [N_CH-1:0] press_o,
  output logic [N_CH-1:0] release_o,
  output logic [N_CH-1:0] long_press_o,
  output logic            tick_o
);

  localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int HC_W  = $clog2(HOLD_TICKS + 1);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [HC_W-1:0]  HOLD_MAX = HC_W'(HOLD_TICKS);

  logic [N_CH-1:0]  s1_q;
  logic [N_CH-1:0]  s2_q;
  logic [DIV_W-1:0] div_q;
  logic [DIV_W-1:0] div_d;
  logic             tick;

  assign tick   = (div_q == DIV_LAST);
  assign div_d  = tick ? '0 : div_q + 1'b1;
  assign tick_o = tick;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      s1_q  <= '0;
      s2_q  <= '0;
      div_q <= '0;
    end else begin
      s1_q  <= button_i;
      s2_q  <= s1_q;
      div_q <= div_d;
    end
  end

  for (genvar gi = 0; gi < N_CH; gi++) begin : g_ch
    // The oldest sample of the window is shifted out without ever being read,
    // so only SAMPLES-1 history bits are stored; the newest comes straight from s2.
    logic [SAMPLES-2:0] hist_q;
    logic [SAMPLES-2:0] hist_d;
    logic [SAMPLES-1:0] win;
    logic               lvl_q, lvl_d;
    logic               press_q, press_d;
    logic               rel_q, rel_d;
    logic               lp_q, lp_d;
    logic [HC_W-1:0]    hc_q, hc_d, hc_inc;

    assign win    = {hist_q, s2_q[gi]};
    assign hc_inc = hc_q + 1'b1;

    always_comb begin
      hist_d  = hist_q;
      lvl_d   = lvl_q;
      press_d = 1'b0;
      rel_d   = 1'b0;
      lp_d    = 1'b0;
      hc_d    = lvl_q ? hc_q : '0;
      if (tick) begin
        hist_d = win[SAMPLES-2:0];
        if (&win && !lvl_q) begin
          lvl_d   = 1'b1;
          press_d = 1'b1;
          hc_d    = '0;
        end else if (~|win && lvl_q) begin
          // A release on the tick that would have fired long_press wins.
          lvl_d = 1'b0;
          rel_d = 1'b1;
          hc_d  = '0;
        end else if (lvl_q && (hc_q < HOLD_MAX)) begin
          hc_d = hc_inc;
          lp_d = (hc_inc == HOLD_MAX);
        end
      end
    end

    always_ff @(posedge clk_i) begin
      if (rst_i) begin
        hist_q  <= '0;
        lvl_q   <= 1'b0;
        press_q <= 1'b0;
        rel_q   <= 1'b0;
        lp_q    <= 1'b0;
        hc_q    <= '0;
      end else begin
        hist_q  <= hist_d;
        lvl_q   <= lvl_d;
        press_q <= press_d;
        rel_q   <= rel_d;
        lp_q    <= lp_d;
        hc_q    <= hc_d;
      end
    end

    assign button_out_o[gi] = lvl_q;
    assign press_o[gi]      = press_q;
    assign release_o[gi]    = rel_q;
    assign long_press_o[gi] = lp_q;
  end

endmodule

// File: tb/tb_pb_debounce_multi.sv
// Directed bench for pb_debounce_multi with N_CH=4, CLK_DIV=4, SAMPLES=4, HOLD_TICKS=5.
// Cycle index cyc counts clock edges after the first reset release; ticks land on multiples of 4.
module tb_pb_debounce_multi;

  logic       clk_i;
  logic       rst_i;
  logic [3:0] button_i;
  logic [3:0] button_out_o;
  logic [3:0] press_o;
  logic [3:0] release_o;
  logic [3:0] long_press_o;
  logic       tick_o;

  pb_debounce_multi #(
    .N_CH(4), .CLK_DIV(4), .SAMPLES(4), .HOLD_TICKS(5)
  ) dut (
    .clk_i        (clk_i),
    .rst_i        (rst_i),
    .button_i     (button_i),
    .button_out_o (button_out_o),
    .press_o      (press_o),
    .release_o    (release_o),
    .long_press_o (long_press_o),
    .tick_o       (tick_o)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  int n_cmp;
  int n_err;
  int cyc;
  int pc[4];
  int rc[4];
  int lc[4];
  int pa[4];
  int ra[4];
  int la[4];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h (cyc %0d)", tag, obs, exp, cyc);
    end
  endtask

  task automatic clear_counts();
    for (int c = 0; c < 4; c++) begin
      pc[c] = 0; rc[c] = 0; lc[c] = 0;
      pa[c] = -1; ra[c] = -1; la[c] = -1;
    end
  endtask

  // Advance one edge, sample 1 time unit later, and log every pulse seen.
  task automatic step();
    @(posedge clk_i);
    #1;
    cyc++;
    for (int c = 0; c < 4; c++) begin
      if (press_o[c] === 1'b1)      begin pc[c]++; pa[c] = cyc; end
      if (release_o[c] === 1'b1)    begin rc[c]++; ra[c] = cyc; end
      if (long_press_o[c] === 1'b1) begin lc[c]++; la[c] = cyc; end
    end
  endtask

  task automatic step_to(input int n);
    while (cyc < n) step();
  endtask

  function automatic int total(input int a[4]);
    return a[0] + a[1] + a[2] + a[3];
  endfunction

  function automatic logic [31:0] all_outs();
    return {15'b0, tick_o, long_press_o, release_o, press_o, button_out_o};
  endfunction

  initial begin
    n_cmp = 0;
    n_err = 0;
    cyc   = 0;
    clear_counts();

    // 1. reset with all buttons held, then tick cadence and first qualification
    rst_i    = 1'b1;
    button_i = 4'hF;
    for (int r = 0; r < 3; r++) begin
      step();
      chk("rst_outs_zero", all_outs(), 32'h0);
    end
    rst_i = 1'b0;
    cyc   = 0;
    clear_counts();
    chk("post_rst_outs_zero", all_outs(), 32'h0);
    for (int k = 1; k <= 16; k++) begin
      step();
      chk("tick_cadence", 32'(tick_o), 32'((k % 4) == 3));
    end
    chk("t1_level_up", 32'(button_out_o), 32'hF);
    chk("t1_press_all", 32'(press_o), 32'hF);
    step();
    chk("t1_press_width", 32'(press_o), 32'h0);
    chk("t1_press_cnt0", 32'(pc[0]), 32'd1);
    button_i = 4'h0;
    step_to(32);
    chk("t1_release_all", 32'(release_o), 32'hF);
    step_to(40);
    chk("t1_release_cnt0", 32'(rc[0]), 32'd1);
    chk("t1_no_long", 32'(total(lc)), 32'd0);

    // 2. clean press/release on ch0; release lands on the would-be long-press tick
    clear_counts();
    step_to(41);
    button_i[0] = 1'b1;
    step_to(55);
    chk("t2_level_before", 32'(button_out_o), 32'h0);
    step();
    chk("t2_level_up", 32'(button_out_o), 32'h1);
    chk("t2_press", 32'(press_o), 32'h1);
    step();
    chk("t2_press_width", 32'(press_o), 32'h0);
    step_to(61);
    button_i[0] = 1'b0;
    step_to(76);
    chk("t2_release", 32'(release_o), 32'h1);
    chk("t2_long_suppressed", 32'(long_press_o), 32'h0);
    step_to(84);
    chk("t2_press_cnt", 32'(total(pc)), 32'd1);
    chk("t2_release_cnt", 32'(total(rc)), 32'd1);
    chk("t2_long_cnt", 32'(total(lc)), 32'd0);

    // 3. bounce on ch1, then a stable hold
    clear_counts();
    for (int i = 0; i < 40; i++) begin
      if ((i % 3) == 0) button_i[1] = ~button_i[1];
      step();
    end
    button_i[1] = 1'b1;
    step_to(135);
    chk("t3_no_pulse_bounce", 32'(total(pc) + total(rc) + total(lc)), 32'd0);
    chk("t3_level_low", 32'(button_out_o), 32'h0);
    step();
    chk("t3_press", 32'(press_o), 32'h2);
    step_to(140);
    button_i[1] = 1'b0;
    step_to(156);
    chk("t3_release", 32'(release_o), 32'h2);
    step_to(160);
    chk("t3_press_cnt", 32'(pc[1]), 32'd1);
    chk("t3_long_cnt", 32'(total(lc)), 32'd0);

    // 4. long press on ch2, then re-arm on a second press
    clear_counts();
    step_to(161);
    button_i[2] = 1'b1;
    step_to(176);
    chk("t4_press", 32'(press_o), 32'h4);
    step_to(196);
    chk("t4_long", 32'(long_press_o), 32'h4);
    step();
    chk("t4_long_width", 32'(long_press_o), 32'h0);
    step_to(221);
    button_i[2] = 1'b0;
    step_to(236);
    chk("t4_release", 32'(release_o), 32'h4);
    step_to(240);
    chk("t4_long_once", 32'(lc[2]), 32'd1);
    chk("t4_long_at", 32'(la[2]), 32'd196);
    clear_counts();
    step_to(241);
    button_i[2] = 1'b1;
    step_to(281);
    button_i[2] = 1'b0;
    step_to(300);
    chk("t4_repress_at", 32'(pa[2]), 32'd256);
    chk("t4_relong_cnt", 32'(lc[2]), 32'd1);
    chk("t4_relong_at", 32'(la[2]), 32'd276);
    chk("t4_rerelease_at", 32'(ra[2]), 32'd296);

    // 5. short press on ch3: too short to qualify, then qualified but released early
    clear_counts();
    step_to(301);
    button_i[3] = 1'b1;
    step_to(313);
    button_i[3] = 1'b0;
    step_to(330);
    chk("t5_short_no_pulse", 32'(total(pc) + total(rc) + total(lc)), 32'd0);
    chk("t5_short_level", 32'(button_out_o), 32'h0);
    step_to(333);
    button_i[3] = 1'b1;
    step_to(349);
    button_i[3] = 1'b0;
    step_to(372);
    chk("t5_press_at", 32'(pa[3]), 32'd348);
    chk("t5_release_at", 32'(ra[3]), 32'd364);
    chk("t5_press_cnt", 32'(pc[3]), 32'd1);
    chk("t5_no_long", 32'(total(lc)), 32'd0);

    // 6. simultaneous press on ch0/ch3, reset while held, re-qualification
    clear_counts();
    step_to(373);
    button_i = 4'h9;
    step_to(388);
    chk("t6_press_pair", 32'(press_o), 32'h9);
    chk("t6_level_pair", 32'(button_out_o), 32'h9);
    step_to(390);
    rst_i = 1'b1;
    step();
    chk("t6_rst_outs_zero", all_outs(), 32'h0);
    step();
    chk("t6_rst_outs_zero2", all_outs(), 32'h0);
    rst_i = 1'b0;
    step_to(394);
    chk("t6_tick_low", 32'(tick_o), 32'h0);
    step();
    chk("t6_tick_first", 32'(tick_o), 32'h1);
    step_to(407);
    chk("t6_level_requal", 32'(button_out_o), 32'h0);
    step();
    chk("t6_press_again", 32'(press_o), 32'h9);
    step_to(412);
    chk("t6_press_cnt0", 32'(pc[0]), 32'd2);
    chk("t6_press_cnt3", 32'(pc[3]), 32'd2);
    chk("t6_no_release", 32'(total(rc)), 32'd0);
    chk("t6_no_long", 32'(total(lc)), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
